// File: rtl/eh2_posit_decode_pipe.sv
// Two-stage posit decoder with valid/ready flow control.
// Optional transfer counters enabled by defining POSIT_DECODE_STATS_EN.
module eh2_posit_decode_pipe #(
  parameter int POSIT_LEN = 32,
  parameter int ES        = 2,
  parameter int FRAC_W    = POSIT_LEN - ES - 3,
  parameter int SCALE_W   = $clog2(POSIT_LEN) + ES + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [POSIT_LEN-1:0] in_posit,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_sign,
  output logic [SCALE_W-1:0]   out_scale,
  output logic [FRAC_W:0]      out_mant,
  output logic                 out_is_zero,
  output logic                 out_is_nar
`ifdef POSIT_DECODE_STATS_EN
  ,
  output logic [31:0]          stat_zero_cnt,
  output logic [31:0]          stat_nar_cnt,
  output logic [31:0]          stat_total_cnt
`endif
);

  localparam int N  = POSIT_LEN;
  localparam int AW = N - 1;
  localparam int KW = $clog2(N) + 1;

  logic          s1_vld_q, s1_vld_d;
  logic          s1_sign_q, s1_sign_d;
  logic [AW-1:0] s1_abs_q, s1_abs_d;
  logic          s1_zero_q, s1_zero_d;
  logic          s1_nar_q, s1_nar_d;

  logic               s2_vld_q, s2_vld_d;
  logic               s2_sign_q, s2_sign_d;
  logic [SCALE_W-1:0] s2_scale_q, s2_scale_d;
  logic [FRAC_W:0]    s2_mant_q, s2_mant_d;
  logic               s2_zero_q, s2_zero_d;
  logic               s2_nar_q, s2_nar_d;

  logic s1_adv;

  always_comb begin
    s1_adv    = ~s2_vld_q | out_ready;
    in_ready  = ~s1_vld_q | s1_adv;
    s1_vld_d  = flush ? 1'b0 : (in_ready ? in_valid : s1_vld_q);
    s1_sign_d = s1_sign_q;
    s1_abs_d  = s1_abs_q;
    s1_zero_d = s1_zero_q;
    s1_nar_d  = s1_nar_q;
    if (in_valid && in_ready && !flush) begin
      s1_sign_d = in_posit[N-1];
      s1_abs_d  = in_posit[N-1] ? (~in_posit[N-2:0] + AW'(1)) : in_posit[N-2:0];
      s1_zero_d = (in_posit == '0);
      s1_nar_d  = in_posit[N-1] && (in_posit[N-2:0] == '0);
    end
  end

  logic [KW-1:0]      k;
  logic               run;
  logic [AW-1:0]      scan;
  logic [AW-3:0]      rem;
  logic [SCALE_W-1:0] regime;
  logic [SCALE_W-1:0] scale_v;

  // The top two bits are always consumed (run >= 1 plus terminator), so the
  // remainder is taken from the low AW-2 bits shifted up by k-1.
  always_comb begin
    k    = '0;
    run  = 1'b1;
    scan = s1_abs_q;
    for (int unsigned i = 0; i < AW; i++) begin
      if (run && (scan[AW-1] == s1_abs_q[AW-1])) k = k + KW'(1);
      else run = 1'b0;
      scan = scan << 1;
    end
    rem     = s1_abs_q[AW-3:0] << (k - KW'(1));
    regime  = s1_abs_q[AW-1] ? (SCALE_W'(k) - SCALE_W'(1)) : (SCALE_W'(0) - SCALE_W'(k));
    scale_v = (regime << ES) + SCALE_W'(rem >> FRAC_W);
  end

  always_comb begin
    s2_vld_d   = flush ? 1'b0 : (s1_adv ? s1_vld_q : s2_vld_q);
    s2_sign_d  = s2_sign_q;
    s2_scale_d = s2_scale_q;
    s2_mant_d  = s2_mant_q;
    s2_zero_d  = s2_zero_q;
    s2_nar_d   = s2_nar_q;
    if (s1_adv && s1_vld_q && !flush) begin
      s2_zero_d = s1_zero_q;
      s2_nar_d  = s1_nar_q;
      if (s1_zero_q || s1_nar_q) begin
        s2_sign_d  = 1'b0;
        s2_scale_d = '0;
        s2_mant_d  = '0;
      end else begin
        s2_sign_d  = s1_sign_q;
        s2_scale_d = scale_v;
        s2_mant_d  = {1'b1, rem[FRAC_W-1:0]};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld_q   <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_abs_q   <= '0;
      s1_zero_q  <= 1'b0;
      s1_nar_q   <= 1'b0;
      s2_vld_q   <= 1'b0;
      s2_sign_q  <= 1'b0;
      s2_scale_q <= '0;
      s2_mant_q  <= '0;
      s2_zero_q  <= 1'b0;
      s2_nar_q   <= 1'b0;
    end else begin
      s1_vld_q   <= s1_vld_d;
      s1_sign_q  <= s1_sign_d;
      s1_abs_q   <= s1_abs_d;
      s1_zero_q  <= s1_zero_d;
      s1_nar_q   <= s1_nar_d;
      s2_vld_q   <= s2_vld_d;
      s2_sign_q  <= s2_sign_d;
      s2_scale_q <= s2_scale_d;
      s2_mant_q  <= s2_mant_d;
      s2_zero_q  <= s2_zero_d;
      s2_nar_q   <= s2_nar_d;
    end
  end

  assign out_valid   = s2_vld_q;
  assign out_sign    = s2_sign_q;
  assign out_scale   = s2_scale_q;
  assign out_mant    = s2_mant_q;
  assign out_is_zero = s2_zero_q;
  assign out_is_nar  = s2_nar_q;

`ifdef POSIT_DECODE_STATS_EN
  logic [31:0] stat_zero_q, stat_zero_d;
  logic [31:0] stat_nar_q, stat_nar_d;
  logic [31:0] stat_total_q, stat_total_d;

  always_comb begin
    stat_zero_d  = stat_zero_q;
    stat_nar_d   = stat_nar_q;
    stat_total_d = stat_total_q;
    if (s2_vld_q && out_ready) begin
      stat_total_d = stat_total_q + 32'd1;
      if (s2_zero_q) stat_zero_d = stat_zero_q + 32'd1;
      if (s2_nar_q)  stat_nar_d  = stat_nar_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_zero_q  <= '0;
      stat_nar_q   <= '0;
      stat_total_q <= '0;
    end else begin
      stat_zero_q  <= stat_zero_d;
      stat_nar_q   <= stat_nar_d;
      stat_total_q <= stat_total_d;
    end
  end

  assign stat_zero_cnt  = stat_zero_q;
  assign stat_nar_cnt   = stat_nar_q;
  assign stat_total_cnt = stat_total_q;
`endif

endmodule

// File: tb/tb_eh2_posit_decode_pipe.sv
// Directed and randomized checks of the pipelined posit decoder at
// N=32/ES=2 (directed) and N=16/ES=1, N=8/ES=0 (random vs model).
module tb_eh2_posit_decode_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Main instance: N=32, ES=2
  logic        a_flush = 0, a_in_valid = 0, a_in_ready, a_out_valid, a_out_ready = 0;
  logic [31:0] a_in_posit = '0;
  logic        a_sign, a_zero, a_nar;
  logic [7:0]  a_scale;
  logic [27:0] a_mant;

  // Random instances share handshake controls
  logic        r_flush = 0, r_in_valid = 0, r_out_ready = 0;
  logic [15:0] r_word = '0;
  logic        b_in_ready, b_out_valid, b_sign, b_zero, b_nar;
  logic [5:0]  b_scale;
  logic [12:0] b_mant;
  logic        c_in_ready, c_out_valid, c_sign, c_zero, c_nar;
  logic [3:0]  c_scale;
  logic [5:0]  c_mant;

`ifdef POSIT_DECODE_STATS_EN
  logic [31:0] a_sz, a_sn, a_st, b_sz, b_sn, b_st, c_sz, c_sn, c_st;
`endif

  eh2_posit_decode_pipe #(.POSIT_LEN(32), .ES(2)) dut_a (
    .clk(clk), .rst(rst), .flush(a_flush), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_posit(a_in_posit), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_sign(a_sign), .out_scale(a_scale), .out_mant(a_mant),
    .out_is_zero(a_zero), .out_is_nar(a_nar)
`ifdef POSIT_DECODE_STATS_EN
    , .stat_zero_cnt(a_sz), .stat_nar_cnt(a_sn), .stat_total_cnt(a_st)
`endif
  );

  eh2_posit_decode_pipe #(.POSIT_LEN(16), .ES(1)) dut_b (
    .clk(clk), .rst(rst), .flush(r_flush), .in_valid(r_in_valid), .in_ready(b_in_ready),
    .in_posit(r_word), .out_valid(b_out_valid), .out_ready(r_out_ready),
    .out_sign(b_sign), .out_scale(b_scale), .out_mant(b_mant),
    .out_is_zero(b_zero), .out_is_nar(b_nar)
`ifdef POSIT_DECODE_STATS_EN
    , .stat_zero_cnt(b_sz), .stat_nar_cnt(b_sn), .stat_total_cnt(b_st)
`endif
  );

  eh2_posit_decode_pipe #(.POSIT_LEN(8), .ES(0)) dut_c (
    .clk(clk), .rst(rst), .flush(r_flush), .in_valid(r_in_valid), .in_ready(c_in_ready),
    .in_posit(r_word[7:0]), .out_valid(c_out_valid), .out_ready(r_out_ready),
    .out_sign(c_sign), .out_scale(c_scale), .out_mant(c_mant),
    .out_is_zero(c_zero), .out_is_nar(c_nar)
`ifdef POSIT_DECODE_STATS_EN
    , .stat_zero_cnt(c_sz), .stat_nar_cnt(c_sn), .stat_total_cnt(c_st)
`endif
  );

  typedef struct {
    logic [31:0] p;
    logic        sign;
    int          scale;
    logic [27:0] mant;
    logic        zero;
    logic        nar;
  } vec_t;

  typedef struct {
    logic   sign;
    int     scale;
    longint mant;
    logic   zero;
    logic   nar;
  } dec_t;

  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference decoder: walks the bit string from the MSB downward.
  function automatic dec_t model(input longint p_in, input int n, input int es);
    dec_t   d;
    longint mask, p, a;
    int     pos, k, e, fw;
    logic   r;
    d = '{sign: 1'b0, scale: 0, mant: 0, zero: 1'b0, nar: 1'b0};
    mask = (longint'(1) << n) - 1;
    p = p_in & mask;
    if (p == 0) begin d.zero = 1'b1; return d; end
    if (p == (longint'(1) << (n - 1))) begin d.nar = 1'b1; return d; end
    d.sign = p[n-1];
    a = d.sign ? ((-p) & mask) : p;
    pos = n - 2;
    r = a[pos];
    k = 0;
    while (pos >= 0 && a[pos] == r) begin k++; pos--; end
    pos--;
    e = 0;
    for (int j = 0; j < es; j++) begin
      e = e * 2 + ((pos >= 0) ? int'(a[pos]) : 0);
      pos--;
    end
    fw = n - es - 3;
    d.mant = 1;
    for (int j = 0; j < fw; j++) begin
      d.mant = d.mant * 2 + ((pos >= 0) ? longint'(a[pos]) : 0);
      pos--;
    end
    d.scale = (r ? (k - 1) : -k) * (1 << es) + e;
    return d;
  endfunction

  vec_t        vt[13];
  logic [31:0] bw[4];
  int          bs[4];
  logic [15:0] sbq[$];
  int          idx, got;
  int          n_tot, n_z16, n_n16, n_z8, n_n8;

  task automatic sb_step();
    logic [15:0] w;
    dec_t        e16, e8;
    #1;
    if (r_in_valid && b_in_ready) sbq.push_back(r_word);
    if (b_out_valid && r_out_ready) begin
      if (sbq.size() == 0) begin
        chk("sb_underflow", 1, 0);
      end else begin
        w = sbq.pop_front();
        e16 = model(longint'(w), 16, 1);
        e8  = model(longint'(w[7:0]), 8, 0);
        chk("r16_sign", b_sign, e16.sign);
        chk("r16_scale", longint'($signed(b_scale)), e16.scale);
        chk("r16_mant", longint'(b_mant), e16.mant);
        chk("r16_zero", b_zero, e16.zero);
        chk("r16_nar", b_nar, e16.nar);
        chk("r8_valid", c_out_valid, 1);
        chk("r8_sign", c_sign, e8.sign);
        chk("r8_scale", longint'($signed(c_scale)), e8.scale);
        chk("r8_mant", longint'(c_mant), e8.mant);
        chk("r8_zero", c_zero, e8.zero);
        chk("r8_nar", c_nar, e8.nar);
        n_tot++;
        n_z16 += int'(e16.zero);
        n_n16 += int'(e16.nar);
        n_z8  += int'(e8.zero);
        n_n8  += int'(e8.nar);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    vt[0]  = '{32'h40000000, 1'b0,    0, 28'h8000000, 1'b0, 1'b0};
    vt[1]  = '{32'h48000000, 1'b0,    1, 28'h8000000, 1'b0, 1'b0};
    vt[2]  = '{32'hC0000000, 1'b1,    0, 28'h8000000, 1'b0, 1'b0};
    vt[3]  = '{32'h20000000, 1'b0,   -4, 28'h8000000, 1'b0, 1'b0};
    vt[4]  = '{32'h7FFFFFFF, 1'b0,  120, 28'h8000000, 1'b0, 1'b0};
    vt[5]  = '{32'h00000001, 1'b0, -120, 28'h8000000, 1'b0, 1'b0};
    vt[6]  = '{32'h00000000, 1'b0,    0, 28'h0000000, 1'b1, 1'b0};
    vt[7]  = '{32'h80000000, 1'b0,    0, 28'h0000000, 1'b0, 1'b1};
    vt[8]  = '{32'h40000001, 1'b0,    0, 28'h8000001, 1'b0, 1'b0};
    vt[9]  = '{32'h5A000000, 1'b0,    3, 28'hA000000, 1'b0, 1'b0};
    vt[10] = '{32'hFFFFFFFF, 1'b1, -120, 28'h8000000, 1'b0, 1'b0};
    vt[11] = '{32'h70000000, 1'b0,    8, 28'h8000000, 1'b0, 1'b0};
    vt[12] = '{32'hB0000000, 1'b1,    2, 28'h8000000, 1'b0, 1'b0};
    bw = '{32'h40000000, 32'h48000000, 32'h20000000, 32'h70000000};
    bs = '{0, 1, -4, 8};
    n_tot = 0; n_z16 = 0; n_n16 = 0; n_z8 = 0; n_n8 = 0;

    // Reset state
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_in_ready", a_in_ready, 1);
    chk("rst_scale", longint'(a_scale), 0);
    chk("rst_mant", longint'(a_mant), 0);

    // Back-to-back directed vectors, out_ready held high
    a_out_ready = 1'b1;
    for (int i = 0; i <= 13; i++) begin
      if (i < 13) begin
        a_in_valid = 1'b1;
        a_in_posit = vt[i].p;
      end else begin
        a_in_valid = 1'b0;
      end
      #1 chk("vec_in_ready", a_in_ready, 1);
      step();
      if (i >= 1) begin
        chk("vec_valid", a_out_valid, 1);
        chk("vec_sign", a_sign, vt[i-1].sign);
        chk("vec_scale", longint'($signed(a_scale)), vt[i-1].scale);
        chk("vec_mant", longint'(a_mant), longint'(vt[i-1].mant));
        chk("vec_zero", a_zero, vt[i-1].zero);
        chk("vec_nar", a_nar, vt[i-1].nar);
      end
    end
    step();
    chk("drain_valid", a_out_valid, 0);

    // Backpressure: 5 stalled cycles while offering 4 words
    a_out_ready = 1'b0;
    a_in_valid  = 1'b1;
    a_in_posit  = bw[0];
    idx = 0;
    for (int c = 0; c < 5; c++) begin
      #1;
      if (a_in_ready) idx++;
      step();
      a_in_valid = (idx < 4);
      a_in_posit = (idx < 4) ? bw[idx] : '0;
      if (c >= 1) begin
        chk("bp_hold_valid", a_out_valid, 1);
        chk("bp_hold_scale", longint'($signed(a_scale)), 0);
        chk("bp_hold_mant", longint'(a_mant), 28'h8000000);
      end
    end
    chk("bp_accepts", idx, 2);
    #1 chk("bp_in_ready", a_in_ready, 0);
    a_out_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 12 && got < 4; c++) begin
      #1;
      if (a_in_valid && a_in_ready) idx++;
      if (a_out_valid) begin
        chk("bp_order_scale", longint'($signed(a_scale)), bs[got]);
        got++;
      end
      step();
      a_in_valid = (idx < 4);
      a_in_posit = (idx < 4) ? bw[idx] : '0;
    end
    chk("bp_results", got, 4);
    #1 chk("bp_no_dup", a_out_valid, 0);

    // Flush with both stages full and a third word offered
    a_out_ready = 1'b0;
    a_in_valid  = 1'b1;
    a_in_posit  = 32'h48000000;
    step();
    step();
    chk("fl_full", a_out_valid, 1);
    a_in_posit = 32'h20000000;
    a_flush = 1'b1;
    step();
    a_flush = 1'b0;
    a_in_valid = 1'b0;
    chk("fl_out_valid", a_out_valid, 0);
    a_out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step();
      chk("fl_no_result", a_out_valid, 0);
    end

    // Random stream against the reference model, random backpressure
    for (int c = 0; c < 400; c++) begin
      r_in_valid = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 9))
        0:       r_word = 16'h0000;
        1:       r_word = 16'h8000;
        2:       r_word = 16'h1280;
        3:       r_word = 16'h7F00 | 16'($urandom_range(0, 255));
        default: r_word = 16'($urandom);
      endcase
      r_out_ready = ($urandom_range(0, 3) != 0);
      sb_step();
    end
    r_in_valid  = 1'b0;
    r_out_ready = 1'b1;
    for (int c = 0; c < 6; c++) sb_step();
    chk("sb_empty", sbq.size(), 0);
    chk("sb_transfers_nonzero", (n_tot > 100) ? 1 : 0, 1);
`ifdef POSIT_DECODE_STATS_EN
    chk("st16_total", b_st, n_tot);
    chk("st16_zero", b_sz, n_z16);
    chk("st16_nar", b_sn, n_n16);
    chk("st8_total", c_st, n_tot);
    chk("st8_zero", c_sz, n_z8);
    chk("st8_nar", c_sn, n_n8);
`endif

    // Reset mid-stream clears outputs asynchronously
    a_out_ready = 1'b0;
    a_in_valid  = 1'b1;
    a_in_posit  = 32'h48000000;
    step();
    step();
    chk("mr_full", a_out_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("mr_out_valid", a_out_valid, 0);
    chk("mr_scale", longint'(a_scale), 0);
    chk("mr_mant", longint'(a_mant), 0);
`ifdef POSIT_DECODE_STATS_EN
    chk("mr_stat_clear", b_st, 0);
`endif
    a_in_valid = 1'b0;
    step();
    rst = 1'b0;
    #1 chk("mr_in_ready", a_in_ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
